dbus_arbiter: RTL

//  Shares the single data-side bus (sync 1-cycle RAM, UART I/O window, debug LED register)

---
 rtl/dbus_pkg.sv | 39 +++
 rtl/rr_arb2.sv | 40 ++++
 rtl/dbus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared types and default address map for the data-bus arbiter.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    R_RAM,
    R_IO,
    R_DBG,
    R_NONE
  } region_e;

  localparam logic [15:0] RAM_HI   = 16'h0000;
  localparam logic [15:0] IO_HI    = 16'hE000;
  localparam logic [31:0] DBG_ADDR = 32'hF000_0000;

  // Map a byte address onto a bus region; anything outside the map is R_NONE.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [15:0] ram_hi,
                                            input logic [15:0] io_hi,
                                            input logic [31:0] dbg_addr);
    region_e r;
    if (addr[31:16] == ram_hi) begin
      r = R_RAM;
    end else if (addr[31:16] == io_hi) begin
      r = R_IO;
    end else if (addr == dbg_addr) begin
      r = R_DBG;
    end else begin
      r = R_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. lp holds the last granted index; on a tie the
// other master wins, so continuous requests from both alternate.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic lp_q, lp_d;

  // Grant selection: single requester wins outright, a tie goes to !lp.
  always_comb begin
    gnt_onehot = 2'b00;
    if (req == 2'b11) begin
      gnt_onehot = lp_q ? 2'b01 : 2'b10;
    end else begin
      gnt_onehot = req;
    end
  end

  // Last-grant pointer moves only when a grant is actually taken.
  always_comb begin
    lp_d = lp_q;
    if (advance && (req != 2'b00)) begin
      lp_d = gnt_onehot[1];
    end
  end

  // Reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_q <= 1'b1;
    end else begin
      lp_q <= lp_d;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-side bus arbiter: round-robin between two masters, region decode,
// three-cycle access sequencing (grant, access, response) and debug LED register.
module dbus_arbiter #(
  parameter int unsigned  RAM_AW   = 8,
  parameter logic [15:0]  RAM_HI   = dbus_pkg::RAM_HI,
  parameter logic [15:0]  IO_HI    = dbus_pkg::IO_HI,
  parameter logic [31:0]  DBG_ADDR = dbus_pkg::DBG_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [7:0]        io_rdata,
  output logic [7:0]        dbg_led
);

  import dbus_pkg::*;

  state_e            state_q, state_d;
  region_e           region_q, region_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        led_q, led_d;

  logic [1:0]        arb_gnt;
  logic              arb_advance;
  logic [31:0]       sel_addr;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              in_acc;
  logic              in_resp;

  assign arb_advance = (state_q == IDLE);
  assign sel_addr    = arb_gnt[1] ? m1_addr : m0_addr;
  assign in_acc      = (state_q == ACC);
  assign in_resp     = (state_q == RESP);

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        ({m1_req, m0_req}),
    .advance    (arb_advance),
    .gnt_onehot (arb_gnt)
  );

  // Next-state: latch the winning request in IDLE, perform DBG writes in ACC.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    id_d       = id_q;
    we_d       = we_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    led_d      = led_q;
    unique case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d    = ACC;
          id_d       = arb_gnt[1];
          we_d       = arb_gnt[1] ? m1_we : m0_we;
          wdata_d    = arb_gnt[1] ? m1_wdata : m0_wdata;
          ram_addr_d = sel_addr[RAM_AW+1:2];
          region_d   = decode_region(sel_addr, RAM_HI, IO_HI, DBG_ADDR);
        end
      end
      ACC: begin
        state_d = RESP;
        if (we_q && (region_q == R_DBG)) begin
          led_d = wdata_q[7:0];
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      region_q   <= R_NONE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      id_q       <= id_d;
      we_q       <= we_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      led_q      <= led_d;
    end
  end

  // Response mux: read data by region, zero for writes; unmapped flags err.
  always_comb begin
    resp_data = 32'h0;
    resp_err  = (region_q == R_NONE);
    if (!we_q) begin
      unique case (region_q)
        R_RAM:   resp_data = ram_rdata;
        R_IO:    resp_data = {24'b0, io_rdata};
        R_DBG:   resp_data = {24'b0, led_q};
        R_NONE:  resp_data = 32'h0;
        default: resp_data = 32'h0;
      endcase
    end
  end

  // Bus-side outputs; strobes only during ACC.
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_wdata = wdata_q;
    io_wdata  = wdata_q;
    ram_we    = in_acc && we_q && (region_q == R_RAM);
    io_we     = in_acc && we_q && (region_q == R_IO);
    dbg_led   = led_q;
  end

  // Master-side outputs; only the latched master sees done/rdata/err.
  always_comb begin
    m0_gnt   = arb_advance && arb_gnt[0];
    m1_gnt   = arb_advance && arb_gnt[1];
    m0_done  = in_resp && !id_q;
    m1_done  = in_resp && id_q;
    m0_rdata = m0_done ? resp_data : 32'h0;
    m1_rdata = m1_done ? resp_data : 32'h0;
    m0_err   = m0_done && resp_err;
    m1_err   = m1_done && resp_err;
  end

endmodule
